// File: rtl/text_writer.sv
// text_writer: turns an ASCII byte stream into writes to a character buffer.
// It tracks a text cursor and handles CR, LF and BS.
// Optional feature: define TEXT_WRITER_CLEAR_EN so that form feed (0x0C)
// clears the whole screen to spaces, one cell per cycle.
module text_writer #(
  parameter int NCOL = 80,
  parameter int NROW = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [6:0] col_w,
  output logic [4:0] row_w,
  output logic [6:0] din,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [6:0] LAST_COL = 7'(NCOL - 1);
  localparam logic [4:0] LAST_ROW = 5'(NROW - 1);

  state_t state;
  logic   accept;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef TEXT_WRITER_CLEAR_EN
  logic busy_r;
  assign busy = busy_r;
`else
  assign busy = 1'b0;
`endif

  // Row increment with wrap to the top (no scrolling).
  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == LAST_ROW) ? '0 : r + 5'd1;
  endfunction

  // Byte decode, cursor update, buffer write strobe and clear sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      col_w   <= '0;
      row_w   <= '0;
      din     <= '0;
      cur_col <= '0;
      cur_row <= '0;
`ifdef TEXT_WRITER_CLEAR_EN
      busy_r  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
              wr_en <= 1'b1;
              col_w <= cur_col;
              row_w <= cur_row;
              din   <= in_data[6:0];
              if (cur_col == LAST_COL) begin
                cur_col <= '0;
                cur_row <= next_row(cur_row);
              end else begin
                cur_col <= cur_col + 7'd1;
              end
            end else if (in_data == 8'h0D) begin
              cur_col <= '0;
            end else if (in_data == 8'h0A) begin
              cur_col <= '0;
              cur_row <= next_row(cur_row);
            end else if (in_data == 8'h08 && cur_col != '0) begin
              cur_col <= cur_col - 7'd1;
              wr_en   <= 1'b1;
              col_w   <= cur_col - 7'd1;
              row_w   <= cur_row;
              din     <= 7'h20;
`ifdef TEXT_WRITER_CLEAR_EN
            end else if (in_data == 8'h0C) begin
              // The first clear strobe goes out with acceptance; col_w/row_w
              // then double as the sweep position during CLEAR.
              state  <= CLEAR;
              busy_r <= 1'b1;
              wr_en  <= 1'b1;
              col_w  <= '0;
              row_w  <= '0;
              din    <= 7'h20;
`endif
            end
          end
        end
        CLEAR: begin
          if (col_w == LAST_COL && row_w == LAST_ROW) begin
            state   <= IDLE;
            cur_col <= '0;
            cur_row <= '0;
`ifdef TEXT_WRITER_CLEAR_EN
            busy_r  <= 1'b0;
`endif
          end else begin
            wr_en <= 1'b1;
            if (col_w == LAST_COL) begin
              col_w <= '0;
              row_w <= row_w + 5'd1;
            end else begin
              col_w <= col_w + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
